sd_host_reg_bank: RTL
=====================

// Module: sd_host_reg_bank
// PURPOSE
//  Storage/control stage directly downstream of the CPU register decoder.
//  Latches decoded CPU writes (one-hot wr_enb + wr_data) into the SD host registers.
//  Runs the command-issue and data-inhibit handshakes toward the command/data engines.
//  Keeps W1C interrupt status and returns every register value for CPU reads (rd_*).
// PARAMETERS
//  ERR_W   4   number of error flags from command engine (032h bits [ERR_W-1:0])
// PORTS
//  clk            in   1   single clock, all state on rising edge
//  reset_n        in   1   asynchronous, active-low reset
//  wr_enb         in   13  one-hot write strobe from decoder; bit map in sd_reg_defs.vh
//  wr_data        in   32  write data qualified by wr_enb
//  cmd_done       in   1   1-cycle pulse: command engine finished current command
//  cmd_err        in   ERR_W  error flags, valid with cmd_done
//  dat_block_done in   1   1-cycle pulse: one data block transferred
//  dat_done       in   1   1-cycle pulse: data transfer finished
//  cmd_start      out  1   1-cycle pulse: launch command held in arg/cmd regs
//  arg_reg        out  32  008h argument
//  cmd_reg        out  16  00Eh command; xfer_mode out 16 00Ch; blk_size out 16 004h
//  rd_004h..rd_032h out 32 readback for 004,006,008,00C,00E,024,030,032 (zero-extended)
//  irq            out  1   registered interrupt request
// BEHAVIOUR
//  Reset: every register, cmd_start, irq = 0; FSM = CMD_IDLE; async assert, sync release.
//  wr_enb bits 004/006/008/00C: load wr_data[15:0] (008h: [31:0]) next edge; latency 1.
//  wr_enb bits 010/012/02A/054 and 024 (RO) ignored; 030/032 are W1C on wr_data[15:0].
//  Present state 024h: bit0 cmd_inhibit, bit1 dat_inhibit; other bits 0.
//  Cmd FSM: CMD_IDLE --(00E write & !cmd_inhibit)--> CMD_ISSUE (cmd_start=1, one cycle,
//   cmd_inhibit=1; dat_inhibit=1 if wr_data[5] data-present) --> CMD_WAIT --cmd_done--> CMD_IDLE.
//  00E write while cmd_inhibit=1 (incl. same cycle as cmd_done): dropped, cmd_reg unchanged.
//  00C write while dat_inhibit=1: dropped.
//  cmd_done: cmd_inhibit cleared; 030h bit0 set; 032h[ERR_W-1:0] |= cmd_err;
//   if cmd_err!=0 also clears dat_inhibit (no data phase).
//  dat_done: dat_inhibit cleared; 030h bit1 set. dat_done with dat_inhibit=0: bit1 still set.
//  dat_block_done with xfer_mode[1]=1: blk_count -1, saturates at 0.
//   Simultaneous CPU 006h write: write wins.
//  W1C vs hardware set same cycle on same bit: set wins (bit reads 1).
//  030h bit15 = |032h (combinational, not storable); W1C on bit15 ignored.
//  irq registered: next edge = |030h[14:0] | |032h; clears 1 cycle after status cleared.
//  cmd_done in CMD_IDLE/CMD_ISSUE: status still updated; FSM ignores it.
//  Reset mid-command: FSM to CMD_IDLE, inhibits cleared; no cmd_start after release.
// STRUCTURE
//  sd_reg_defs.vh: wr_enb bit indices (0:004 1:006 2:008 3:00A 4:00C 5:00E 6:010 7:012
//   8:024 9:02A 10:030 11:032 12:054), status bit positions, FSM encodings
//   (CMD_IDLE=0, CMD_ISSUE=1, CMD_WAIT=2).
//  Sub-module sd_w1c_reg (WIDTH param): hw set, CPU W1C, set-wins; used for 030h and 032h.
// TESTING
//  1 reset_n low mid-CMD_WAIT -> cmd_start=0, rd_024h=0, irq=0 immediately; stays 0 after release.
//  2 wr 008h=0xDEADBEEF, wr 00Eh=0x0020 -> cmd_start 1 cycle later,
//    rd_024h=0x3, arg_reg=0xDEADBEEF.
//  3 second 00Eh=0x0011 write during CMD_WAIT -> no cmd_start, rd_00Eh stays 0x0020.
//  4 cmd_done, cmd_err=4'b0010 -> rd_030h=0x8001, rd_032h=0x0002, rd_024h=0x0, irq=1 next cycle.
//  5 wr 032h=0x0002 same cycle as cmd_done err=0x2 -> rd_032h stays 0x0002;
//    then wr 032h=0x2, wr 030h=0x1 -> irq=0.
//  6 blk_count=2, xfer_mode=0x0002, three dat_block_done -> 1,0,0;
//    dat_done -> rd_030h bit1=1, dat_inhibit=0.

Source files
------------

// File: rtl/sd_host_reg_bank_pkg.sv
// rtl/sd_host_reg_bank_pkg.sv - write-strobe map, status bit positions and command FSM encoding
package sd_host_reg_bank_pkg;

  localparam int WE_W   = 13;
  localparam int WE_004 = 0;
  localparam int WE_006 = 1;
  localparam int WE_008 = 2;
  localparam int WE_00A = 3;
  localparam int WE_00C = 4;
  localparam int WE_00E = 5;
  localparam int WE_010 = 6;
  localparam int WE_012 = 7;
  localparam int WE_024 = 8;
  localparam int WE_02A = 9;
  localparam int WE_030 = 10;
  localparam int WE_032 = 11;
  localparam int WE_054 = 12;

  localparam int INT_W          = 15;
  localparam int INT_CMD_DONE   = 0;
  localparam int INT_DAT_DONE   = 1;
  localparam int PS_CMD_INHIBIT = 0;
  localparam int PS_DAT_INHIBIT = 1;
  localparam int CMD_DATA_PRESENT = 5;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_ISSUE = 2'd1,
    CMD_WAIT  = 2'd2
  } cmd_state_e;

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

endpackage

// File: rtl/sd_w1c_reg.sv
// rtl/sd_w1c_reg.sv - status register with hardware set and CPU write-one-to-clear, set wins
module sd_w1c_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] set_i,
  input  logic [WIDTH-1:0] clr_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  assign q_d = (q_q & ~clr_i) | set_i;
  assign q_o = q_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q_q <= '0;
    else          q_q <= q_d;
  end

endmodule

// File: rtl/sd_host_reg_bank.sv
// rtl/sd_host_reg_bank.sv - SD host register storage, command/data inhibit handshake and W1C interrupts
module sd_host_reg_bank
  import sd_host_reg_bank_pkg::*;
#(
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WE_W-1:0]  wr_enb,
  input  logic [31:0]      wr_data,
  input  logic             cmd_done,
  input  logic [ERR_W-1:0] cmd_err,
  input  logic             dat_block_done,
  input  logic             dat_done,
  output logic             cmd_start,
  output logic [31:0]      arg_reg,
  output logic [15:0]      cmd_reg,
  output logic [15:0]      xfer_mode,
  output logic [15:0]      blk_size,
  output logic [31:0]      rd_004h,
  output logic [31:0]      rd_006h,
  output logic [31:0]      rd_008h,
  output logic [31:0]      rd_00Ch,
  output logic [31:0]      rd_00Eh,
  output logic [31:0]      rd_024h,
  output logic [31:0]      rd_030h,
  output logic [31:0]      rd_032h,
  output logic             irq
);

  logic [15:0]      blk_size_q, blk_count_q, blk_count_d, xfer_mode_q, cmd_q;
  logic [31:0]      arg_q;
  logic             dat_inhibit_q, cmd_start_q, irq_q;
  cmd_state_e       state_q;
  logic             cmd_inhibit;
  logic [INT_W-1:0] int_set, int_clr, int_q;
  logic [ERR_W-1:0] err_set, err_clr, err_q;
  logic             unused_we;

  assign cmd_inhibit = (state_q != CMD_IDLE);
  assign unused_we = ^{wr_enb[WE_00A], wr_enb[WE_010], wr_enb[WE_012],
                       wr_enb[WE_024], wr_enb[WE_02A], wr_enb[WE_054]};

  always_comb begin
    blk_count_d = blk_count_q;
    if (wr_enb[WE_006])
      blk_count_d = wr_data[15:0];
    else if (dat_block_done && xfer_mode_q[1] && blk_count_q != 16'd0)
      blk_count_d = blk_count_q - 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_size_q  <= '0;
      blk_count_q <= '0;
      arg_q       <= '0;
      xfer_mode_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      blk_count_q <= blk_count_d;
      if (wr_enb[WE_004]) blk_size_q <= wr_data[15:0];
      if (wr_enb[WE_008]) arg_q <= wr_data;
      if (wr_enb[WE_00C] && !dat_inhibit_q) xfer_mode_q <= wr_data[15:0];
      irq_q <= (|int_q) | (|err_q);
    end
  end

  // A command launches only from idle; cmd_done is honoured only once the start pulse is out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= CMD_IDLE;
      cmd_start_q   <= 1'b0;
      dat_inhibit_q <= 1'b0;
      cmd_q         <= '0;
    end else begin
      cmd_start_q <= 1'b0;
      if (dat_done) dat_inhibit_q <= 1'b0;
      case (state_q)
        CMD_IDLE: begin
          if (wr_enb[WE_00E]) begin
            cmd_q       <= wr_data[15:0];
            cmd_start_q <= 1'b1;
            state_q     <= CMD_ISSUE;
            if (wr_data[CMD_DATA_PRESENT]) dat_inhibit_q <= 1'b1;
          end
        end
        CMD_ISSUE: state_q <= CMD_WAIT;
        CMD_WAIT: begin
          if (cmd_done) begin
            state_q <= CMD_IDLE;
            if (|cmd_err) dat_inhibit_q <= 1'b0;
          end
        end
        default: state_q <= CMD_IDLE;
      endcase
    end
  end

  always_comb begin
    int_set               = '0;
    int_set[INT_CMD_DONE] = cmd_done;
    int_set[INT_DAT_DONE] = dat_done;
  end
  assign int_clr = wr_enb[WE_030] ? wr_data[INT_W-1:0] : '0;
  assign err_set = cmd_done ? cmd_err : '0;
  assign err_clr = wr_enb[WE_032] ? wr_data[ERR_W-1:0] : '0;

  sd_w1c_reg #(.WIDTH(INT_W)) u_int_status (
    .clk(clk), .reset_n(reset_n), .set_i(int_set), .clr_i(int_clr), .q_o(int_q)
  );

  sd_w1c_reg #(.WIDTH(ERR_W)) u_err_status (
    .clk(clk), .reset_n(reset_n), .set_i(err_set), .clr_i(err_clr), .q_o(err_q)
  );

  assign cmd_start = cmd_start_q;
  assign arg_reg   = arg_q;
  assign cmd_reg   = cmd_q;
  assign xfer_mode = xfer_mode_q;
  assign blk_size  = blk_size_q;
  assign irq       = irq_q;
  assign rd_004h   = zext16(blk_size_q);
  assign rd_006h   = zext16(blk_count_q);
  assign rd_008h   = arg_q;
  assign rd_00Ch   = zext16(xfer_mode_q);
  assign rd_00Eh   = zext16(cmd_q);
  assign rd_030h   = {16'h0000, |err_q, int_q};
  assign rd_032h   = {{(32-ERR_W){1'b0}}, err_q};

  always_comb begin
    rd_024h                 = '0;
    rd_024h[PS_CMD_INHIBIT] = cmd_inhibit;
    rd_024h[PS_DAT_INHIBIT] = dat_inhibit_q;
  end

endmodule
